vector_list_sequencer: RTL and testbench

- Walks a display list of beam commands held in a synchronous-read RAM and issues one jump or draw at a time to the vector control block, using that block's x/y/jump/draw/ready interface.
- Restarts the list once per frame from a free-running frame timer, so the picture refreshes at a fixed rate.
- Sits between the display-list RAM (written by the host) and the control block that drives the DAC and line generator.
- Also owns the beam intensity register and reports frame overruns.

---
 rtl/vector_pkg.sv | 32 +++
 rtl/vector_list_sequencer_frame_timer.sv | 29 ++
 rtl/vector_list_sequencer.sv | 173 +++++++++++++++++
 tb/tb_vector_list_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared opcodes, field positions and state encoding
// for the vector display-list sequencer.
package vector_pkg;

  localparam int COORD_W = 12;
  localparam int INT_W   = 8;

  localparam int OP_HI = 31;
  localparam int OP_LO = 30;
  localparam int X_HI  = 23;
  localparam int X_LO  = 12;
  localparam int Y_HI  = 11;
  localparam int Y_LO  = 0;
  localparam int I_HI  = 7;
  localparam int I_LO  = 0;

  typedef enum logic [1:0] {
    OP_JUMP   = 2'b00,
    OP_DRAW   = 2'b01,
    OP_INTENS = 2'b10,
    OP_END    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HOLD
  } state_e;

endpackage

// File: rtl/vector_list_sequencer_frame_timer.sv
// Free-running frame period counter; frame_tick
// marks the cycle in which the count wraps to 0.
module frame_timer #(
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int W = $clog2(FRAME_CYCLES);
  localparam logic [W-1:0] LAST = W'(FRAME_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Wrap detection and next count.
  always_comb begin
    frame_tick = (cnt_q == LAST);
    cnt_d      = frame_tick ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vector_list_sequencer.sv
// Walks the display list once per frame and issues
// jump/draw strobes to the vector control block.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter int unsigned FRAME_CYCLES = 833333,
  parameter int unsigned HOLDOFF      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_rdata,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               jump,
  output logic               draw,
  input  logic               ready,
  output logic [INT_W-1:0]   intensity,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int HW =
    (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               jump_q, jump_d;
  logic               draw_q, draw_d;
  logic               busy_q, busy_d;
  logic               fd_q, fd_d;
  logic               ovr_q, ovr_d;
  logic               isd_q, isd_d;
  logic               tick;
  logic               last;
  op_e                op;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(tick)
  );

  assign op   = op_e'(mem_rdata[OP_HI:OP_LO]);
  assign last = (addr_q == '1);

  // Next-state and output logic; the last list slot
  // finishing acts as an implicit END.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    int_d   = int_q;
    hold_d  = hold_q;
    isd_d   = isd_q;
    busy_d  = busy_q;
    jump_d  = 1'b0;
    draw_d  = 1'b0;
    fd_d    = 1'b0;
    ovr_d   = ovr_q | (tick & busy_q);
    unique case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_JUMP, OP_DRAW: begin
            x_d     = mem_rdata[X_HI:X_LO];
            y_d     = mem_rdata[Y_HI:Y_LO];
            isd_d   = (op == OP_DRAW);
            state_d = S_ISSUE;
          end
          OP_INTENS: begin
            int_d = mem_rdata[I_HI:I_LO];
            if (last) begin
              fd_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_END: begin
            fd_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end
      S_ISSUE: begin
        if (ready) begin
          jump_d  = !isd_q;
          draw_d  = isd_q;
          hold_d  = HW'(HOLDOFF);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q > 1) begin
          hold_d = hold_q - 1'b1;
        end else if (last) begin
          fd_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (enable) begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      int_q   <= '0;
      hold_q  <= '0;
      isd_q   <= 1'b0;
      busy_q  <= 1'b0;
      jump_q  <= 1'b0;
      draw_q  <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      int_q   <= int_d;
      hold_q  <= hold_d;
      isd_q   <= isd_d;
      busy_q  <= busy_d;
      jump_q  <= jump_d;
      draw_q  <= draw_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem_addr   = addr_q;
  assign x          = x_q;
  assign y          = y_q;
  assign jump       = jump_q;
  assign draw       = draw_q;
  assign intensity  = int_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench: two sequencer instances with
// models of the display-list RAM and control block.
module tb_vector_list_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       d;
    logic [11:0] x;
    logic [11:0] y;
    logic [7:0]  i;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks   = 0;
  int failures = 0;

  logic        enable_a, ready_a;
  logic [5:0]  addr_a;
  logic [31:0] rdata_a;
  logic [11:0] x_a, y_a;
  logic        jump_a, draw_a;
  logic [7:0]  intensity_a;
  logic        busy_a, fd_a, ovr_a;
  logic [31:0] ram_a [64];

  logic        enable_b;
  logic [2:0]  addr_b;
  logic [31:0] rdata_b;
  logic [11:0] x_b, y_b;
  logic        jump_b, draw_b;
  logic [7:0]  intensity_b;
  logic        busy_b, fd_b, ovr_b;
  logic [31:0] ram_b [8];

  vector_list_sequencer #(
    .ADDR_W(6), .FRAME_CYCLES(64), .HOLDOFF(2)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a),
    .mem_addr(addr_a), .mem_rdata(rdata_a),
    .x(x_a), .y(y_a), .jump(jump_a),
    .draw(draw_a), .ready(ready_a),
    .intensity(intensity_a), .busy(busy_a),
    .frame_done(fd_a), .overrun(ovr_a)
  );

  vector_list_sequencer #(
    .ADDR_W(3), .FRAME_CYCLES(64), .HOLDOFF(2)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b),
    .mem_addr(addr_b), .mem_rdata(rdata_b),
    .x(x_b), .y(y_b), .jump(jump_b),
    .draw(draw_b), .ready(1'b1),
    .intensity(intensity_b), .busy(busy_b),
    .frame_done(fd_b), .overrun(ovr_b)
  );

  always @(posedge clk) rdata_a <= ram_a[addr_a];
  always @(posedge clk) rdata_b <= ram_b[addr_b];

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(
    logic [1:0] op, int ex, int ey);
    logic [11:0] xx, yy;
    xx = ex[11:0];
    yy = ey[11:0];
    return {op, 6'b0, xx, yy};
  endfunction

  function automatic exp_t mk(
    logic d, int ex, int ey, int ei);
    exp_t e;
    e.d = d;
    e.x = ex[11:0];
    e.y = ey[11:0];
    e.i = ei[7:0];
    return e;
  endfunction

  int strobes_a = 0, last_a = 0, prev_a = 0;
  int strobes_b = 0;

  // Monitor A: every strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (jump_a && draw_a)
        chk("a_both_strobes", 1, 0);
      if (jump_a || draw_a) begin
        strobes_a++;
        prev_a = last_a;
        last_a = cyc;
        if (qa.size() == 0) begin
          chk("a_unexpected_strobe",
              {draw_a, x_a, y_a}, 0);
          if ({draw_a, x_a, y_a} == 0)
            chk("a_unexpected_strobe", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_strobe",
              {draw_a, x_a, y_a, intensity_a},
              {e.d, e.x, e.y, e.i});
        end
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (jump_b || draw_b)) begin
      strobes_b++;
      if (qb.size() == 0) begin
        chk("b_unexpected_strobe", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_strobe",
            {draw_b, x_b, y_b, intensity_b},
            {e.d, e.x, e.y, e.i});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sel_sig(int sel);
    case (sel)
      0: return fd_a;
      1: return fd_b;
      default: return jump_a | draw_a;
    endcase
  endfunction

  task automatic wait_for(int sel, int bound,
                          string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (!sel_sig(sel) && n < bound);
    if (!sel_sig(sel))
      chk({nm, "_timeout"}, 0, 1);
  endtask

  logic b_done = 1'b0;

  // Instance B: 8 DRAWs, no END, 3-bit address.
  initial begin
    enable_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ram_b[i] = ent(2'b01, i * 16 + 1, i);
      qb.push_back(mk(1, i * 16 + 1, i, 0));
    end
    @(posedge reset);
    wait_for(1, 300, "b_done");
    chk("b_addr_at_end", addr_b, 7);
    chk("b_strobe_count", strobes_b, 8);
    enable_b = 1'b0;
    b_done = 1'b1;
  end

  initial begin
    int s0;
    logic seen;
    reset    = 1'b0;
    enable_a = 1'b1;
    ready_a  = 1'b1;
    for (int i = 0; i < 64; i++) ram_a[i] = 0;
    ram_a[0] = ent(2'b00, 100, 200);
    ram_a[1] = ent(2'b01, 4095, 0);
    ram_a[2] = ent(2'b11, 0, 0);
    for (int p = 0; p < 2; p++) begin
      qa.push_back(mk(0, 100, 200, 0));
      qa.push_back(mk(1, 4095, 0, 0));
    end
    step();
    step();
    chk("reset_state",
        {addr_a, x_a, y_a, jump_a, draw_a,
         intensity_a, busy_a, fd_a, ovr_a}, 0);
    reset = 1'b1;

    wait_for(0, 200, "p1_done1");
    chk("p1_draw_gap", last_a - prev_a, 5);
    chk("p1_busy_low", busy_a, 0);
    wait_for(0, 200, "p1_done2");
    chk("p1_busy_low2", busy_a, 0);

    qa.push_back(mk(0, 100, 200, 0));
    qa.push_back(mk(1, 4095, 0, 0));
    s0 = strobes_a;
    wait_for(2, 200, "p2_jump");
    ready_a = 1'b0;
    repeat (20) step();
    chk("p2_stalled", strobes_a, s0 + 1);
    ready_a = 1'b1;
    wait_for(0, 200, "p2_done");
    chk("p2_one_draw", strobes_a, s0 + 2);

    ram_a[0] = ent(2'b10, 0, 8'h80);
    ram_a[1] = ent(2'b00, 5, 5);
    ram_a[2] = ent(2'b11, 0, 0);
    qa.push_back(mk(0, 5, 5, 8'h80));
    s0 = strobes_a;
    wait_for(0, 200, "p3_done");
    chk("p3_strobes", strobes_a, s0 + 1);
    chk("p3_intensity", intensity_a, 8'h80);
    chk("p3_no_overrun", ovr_a, 0);

    for (int i = 0; i < 40; i++) begin
      ram_a[i] = ent(2'b00, i * 3, 4095 - i);
      qa.push_back(mk(0, i * 3, 4095 - i, 8'h80));
    end
    ram_a[40] = ent(2'b11, 0, 0);
    wait_for(0, 600, "p4_done");
    enable_a = 1'b0;
    chk("p4_overrun", ovr_a, 1);
    chk("p4_busy_low", busy_a, 0);
    seen = 1'b0;
    repeat (70) begin
      step();
      seen = seen | busy_a;
    end
    chk("p4_no_restart", seen, 0);
    chk("p4_overrun_sticky", ovr_a, 1);

    ram_a[0] = ent(2'b10, 0, 8'h11);
    ram_a[1] = ent(2'b01, 7, 7);
    ram_a[2] = ent(2'b01, 8, 8);
    ram_a[3] = ent(2'b11, 0, 0);
    qa.push_back(mk(1, 7, 7, 8'h11));
    enable_a = 1'b1;
    wait_for(2, 200, "p5_draw");
    reset = 1'b0;
    #1;
    chk("p5_async_reset",
        {addr_a, x_a, y_a, jump_a, draw_a,
         intensity_a, busy_a, fd_a, ovr_a}, 0);
    step();
    reset = 1'b1;
    s0 = strobes_a;
    seen = 1'b0;
    repeat (30) begin
      step();
      seen = seen | busy_a;
    end
    chk("p5_idle_after_reset",
        {seen, strobes_a}, {1'b0, s0});
    enable_a = 1'b0;

    if (!b_done) wait_for(1, 5, "b_finish");
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
